// File: rtl/prog_ram_pkg.sv
// ============================================================================
// Module      : prog_ram_pkg
// Description : Shared types and default constants for the program RAM.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package prog_ram_pkg;

    localparam int C_ADDR_WIDTH = 8;
    localparam int C_DATA_WIDTH = 16;
    localparam int C_READ_LAT   = 1;

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_LOAD  = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

endpackage

`default_nettype wire

// File: rtl/prog_ram_array.sv
// ============================================================================
// Module      : prog_ram_array
// Description : Single-port synchronous RAM, one write or one read per cycle.
//               Read data is registered and holds until the next read.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_ram_array
    import prog_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int DATA_WIDTH = C_DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  we_i,
    input  logic                  re_i,
    input  logic [ADDR_WIDTH-1:0] addr_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    output logic [DATA_WIDTH-1:0] rdata_o
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] rdata_q;

    // Storage and read register; contents are deliberately never reset.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= wdata_i;
        end else if (re_i) begin
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

`default_nettype wire

// File: rtl/prog_ram.sv
// ============================================================================
// Module      : prog_ram
// Description : Program RAM with power-up clear sweep, streaming program
//               load and a pipelined run-time read/write port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module prog_ram
    import prog_ram_pkg::*;
#(
    parameter int ADDR_WIDTH = C_ADDR_WIDTH,
    parameter int DATA_WIDTH = C_DATA_WIDTH,
    parameter int READ_LAT   = C_READ_LAT
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  ce,
    input  logic                  rw,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic [DATA_WIDTH-1:0] reg_in,
    output logic [DATA_WIDTH-1:0] reg_out,
    output logic                  rd_valid,
    output logic                  busy,
    input  logic                  sweep_req,
    input  logic                  load_valid,
    input  logic [DATA_WIDTH-1:0] load_data,
    input  logic                  load_last,
    output logic                  load_ready
);

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] clr_cnt_q, clr_cnt_d;
    logic [ADDR_WIDTH-1:0] ld_ptr_q, ld_ptr_d;
    logic                  vld1_q;

    logic                  sweep_take;
    logic                  run_acc;
    logic                  run_wr;
    logic                  run_rd;
    logic                  ld_xfer;

    logic                  ram_we;
    logic                  ram_re;
    logic [ADDR_WIDTH-1:0] ram_addr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // A sweep request wins over any access presented in the same cycle.
    assign sweep_take = (state_q == ST_RUN) && sweep_req;
    assign run_acc    = (state_q == ST_RUN) && ce && !sweep_req;
    assign run_wr     = run_acc && !rw;
    assign run_rd     = run_acc && rw;
    assign ld_xfer    = (state_q == ST_LOAD) && load_valid;

    assign busy       = (state_q != ST_RUN);
    assign load_ready = (state_q == ST_LOAD);

    // Mode sequencing: clear sweep, program load, then normal run.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        ld_ptr_d  = ld_ptr_q;
        case (state_q)
            ST_CLEAR: begin
                clr_cnt_d = clr_cnt_q + 1'b1;
                if (clr_cnt_q == LAST_ADDR) begin
                    state_d   = ST_LOAD;
                    clr_cnt_d = '0;
                    ld_ptr_d  = '0;
                end
            end
            ST_LOAD: begin
                if (ld_xfer) begin
                    ld_ptr_d = ld_ptr_q + 1'b1;
                    // Loading stops at the top of memory rather than wrapping.
                    if (load_last || (ld_ptr_q == LAST_ADDR)) begin
                        state_d = ST_RUN;
                    end
                end
            end
            ST_RUN: begin
                if (sweep_req) begin
                    state_d   = ST_CLEAR;
                    clr_cnt_d = '0;
                end
            end
            default: begin
                state_d   = ST_CLEAR;
                clr_cnt_d = '0;
                ld_ptr_d  = '0;
            end
        endcase
    end

    // State and pointer registers.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ld_ptr_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            ld_ptr_q  <= ld_ptr_d;
        end
    end

    // The single RAM port is owned by the sweep, the loader or the user.
    always_comb begin
        ram_we    = 1'b0;
        ram_re    = 1'b0;
        ram_addr  = '0;
        ram_wdata = '0;
        case (state_q)
            ST_CLEAR: begin
                ram_we   = 1'b1;
                ram_addr = clr_cnt_q;
            end
            ST_LOAD: begin
                ram_we    = ld_xfer;
                ram_addr  = ld_ptr_q;
                ram_wdata = load_data;
            end
            ST_RUN: begin
                ram_we    = run_wr;
                ram_re    = run_rd;
                ram_addr  = addr;
                ram_wdata = reg_in;
            end
            default: begin
                ram_we = 1'b0;
            end
        endcase
    end

    prog_ram_array #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_array (
        .clk     (clk),
        .we_i    (ram_we),
        .re_i    (ram_re),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    // First read stage: array data is present in the cycle after acceptance.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            vld1_q <= 1'b0;
        end else begin
            vld1_q <= run_rd;
        end
    end

    generate
        if (READ_LAT == 1) begin : g_lat1
            logic                  fire;
            logic [DATA_WIDTH-1:0] hold_q;

            // A sweep in the delivery cycle suppresses the pending read.
            assign fire = vld1_q && !sweep_take;

            // Keep the last delivered word so reg_out is stable between reads.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    hold_q <= '0;
                end else if (fire) begin
                    hold_q <= ram_rdata;
                end
            end

            assign rd_valid = fire;
            assign reg_out  = fire ? ram_rdata : hold_q;
        end else begin : g_lat2
            logic                  vld2_q;
            logic [DATA_WIDTH-1:0] out_q;

            // Second stage register; reads caught by a sweep are dropped.
            always_ff @(posedge clk or posedge clr) begin
                if (clr) begin
                    vld2_q <= 1'b0;
                    out_q  <= '0;
                end else begin
                    vld2_q <= vld1_q && !sweep_take;
                    if (vld1_q && !sweep_take) begin
                        out_q <= ram_rdata;
                    end
                end
            end

            assign rd_valid = vld2_q && !sweep_take;
            assign reg_out  = out_q;
        end
    endgenerate

endmodule

`default_nettype wire

// File: tb/tb_prog_ram.sv
// ============================================================================
// Module      : tb_prog_ram
// Description : Scoreboard bench for prog_ram; one instance per read latency
//               shares the same stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_prog_ram;

    localparam int AW = 8;
    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          clr = 1'b1;
    logic          ce = 1'b0;
    logic          rw = 1'b0;
    logic          sweep_req = 1'b0;
    logic          load_valid = 1'b0;
    logic          load_last = 1'b0;
    logic [AW-1:0] addr = '0;
    logic [DW-1:0] reg_in = '0;
    logic [DW-1:0] load_data = '0;

    logic [DW-1:0] reg_out1, reg_out2;
    logic          rd_valid1, rd_valid2;
    logic          busy1, busy2;
    logic          load_ready1, load_ready2;

    int cyc    = 0;
    int n_vec  = 0;
    int n_miss = 0;
    int ld_ptr = 0;

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    logic [DW-1:0] img [256];
    logic [DW-1:0] words [11] = '{16'h3803, 16'h0005, 16'h1234, 16'hA5A5,
                                  16'h0F0F, 16'h7FFF, 16'h8000, 16'hFFFF,
                                  16'h0001, 16'h5AC3, 16'h3C00};

    prog_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(1)) u_dut1 (
        .clk(clk), .clr(clr), .ce(ce), .rw(rw), .addr(addr), .reg_in(reg_in),
        .reg_out(reg_out1), .rd_valid(rd_valid1), .busy(busy1),
        .sweep_req(sweep_req), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready1)
    );

    prog_ram #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .READ_LAT(2)) u_dut2 (
        .clk(clk), .clr(clr), .ce(ce), .rw(rw), .addr(addr), .reg_in(reg_in),
        .reg_out(reg_out2), .rd_valid(rd_valid2), .busy(busy2),
        .sweep_req(sweep_req), .load_valid(load_valid), .load_data(load_data),
        .load_last(load_last), .load_ready(load_ready2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: every read pulse must match the oldest expected entry in data
    // and in arrival cycle.
    always @(negedge clk) begin
        exp_t e;
        if (rd_valid1 === 1'b1) begin
            n_vec++;
            if (q1.size() == 0) begin
                n_miss++;
                $display("FAIL lat1_unexpected: rd_valid at cycle %0d data %h, required no pulse", cyc, reg_out1);
            end else begin
                e = q1.pop_front();
                if (e.cyc != cyc || reg_out1 !== e.data) begin
                    n_miss++;
                    $display("FAIL lat1_read: got %h at cycle %0d, required %h at cycle %0d", reg_out1, cyc, e.data, e.cyc);
                end
            end
        end
        if (rd_valid2 === 1'b1) begin
            n_vec++;
            if (q2.size() == 0) begin
                n_miss++;
                $display("FAIL lat2_unexpected: rd_valid at cycle %0d data %h, required no pulse", cyc, reg_out2);
            end else begin
                e = q2.pop_front();
                if (e.cyc != cyc || reg_out2 !== e.data) begin
                    n_miss++;
                    $display("FAIL lat2_read: got %h at cycle %0d, required %h at cycle %0d", reg_out2, cyc, e.data, e.cyc);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ce         = 1'b0;
        rw         = 1'b0;
        sweep_req  = 1'b0;
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic rd(input int a);
        exp_t e;
        ce   = 1'b1;
        rw   = 1'b1;
        addr = AW'(a);
        e.data = img[a];
        e.cyc  = cyc + 1;
        q1.push_back(e);
        e.cyc  = cyc + 2;
        q2.push_back(e);
        step();
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        ce     = 1'b1;
        rw     = 1'b0;
        addr   = AW'(a);
        reg_in = d;
        img[a] = d;
        step();
    endtask

    task automatic ld(input logic [DW-1:0] d, input logic last);
        load_valid  = 1'b1;
        load_data   = d;
        load_last   = last;
        img[ld_ptr] = d;
        ld_ptr++;
        step();
    endtask

    // Clear sweep takes one cycle per address before loading opens.
    task automatic wait_ready(input string name);
        int n = 0;
        while (!(load_ready1 === 1'b1 && load_ready2 === 1'b1) && n < 600) begin
            chk({name, "_busy"}, {30'd0, busy1, busy2}, 32'd3);
            step();
            n++;
        end
        chk({name, "_cycles"}, n, 256);
        for (int i = 0; i < 256; i++) img[i] = '0;
        ld_ptr = 0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 256; a++) rd(a);
        idle();
        repeat (4) step();
    endtask

    initial begin
        for (int i = 0; i < 256; i++) img[i] = '0;

        // Reset state.
        repeat (3) step();
        chk("rst_busy",     {30'd0, busy1, busy2}, 32'd3);
        chk("rst_ready",    {30'd0, load_ready1, load_ready2}, 32'd0);
        chk("rst_rdvalid",  {30'd0, rd_valid1, rd_valid2}, 32'd0);
        chk("rst_regout1",  32'(reg_out1), 32'd0);
        chk("rst_regout2",  32'(reg_out2), 32'd0);
        clr = 1'b0;
        wait_ready("init_sweep");

        // Program load with a stall in the middle.
        for (int i = 0; i < 11; i++) begin
            ld(words[i], i == 10);
            if (i == 4) begin
                idle();
                repeat (3) step();
                chk("load_hold_ready", {30'd0, load_ready1, load_ready2}, 32'd3);
            end
        end
        idle();
        chk("run_busy",  {30'd0, busy1, busy2}, 32'd0);
        chk("run_ready", {30'd0, load_ready1, load_ready2}, 32'd0);
        read_all();

        // Write then immediate read, then idle hold of reg_out.
        wr(7, 16'hBEEF);
        rd(7);
        idle();
        rw = 1'b1;
        repeat (4) step();
        chk("hold_regout1", 32'(reg_out1), 32'h0000BEEF);
        chk("hold_regout2", 32'(reg_out2), 32'h0000BEEF);

        // Sweep with a read in flight and a write in the sweep cycle.
        ce   = 1'b1;
        rw   = 1'b1;
        addr = 8'd7;
        step();
        sweep_req = 1'b1;
        rw        = 1'b0;
        addr      = 8'd1;
        reg_in    = 16'hFFFF;
        step();
        idle();
        chk("sweep_busy",  {30'd0, busy1, busy2}, 32'd3);
        chk("sweep_ready", {30'd0, load_ready1, load_ready2}, 32'd0);
        wait_ready("sweep1");
        ld(16'h1111, 1'b1);
        idle();
        read_all();

        // Full-depth load without load_last, then an extra offered word.
        sweep_req = 1'b1;
        step();
        idle();
        wait_ready("sweep2");
        for (int i = 0; i < 256; i++) ld(16'(i) ^ 16'h5A00, 1'b0);
        idle();
        chk("full_busy",  {30'd0, busy1, busy2}, 32'd0);
        chk("full_ready", {30'd0, load_ready1, load_ready2}, 32'd0);
        load_valid = 1'b1;
        load_data  = 16'hDEAD;
        step();
        chk("extra_ready", {30'd0, load_ready1, load_ready2}, 32'd0);
        idle();
        rd(0);
        rd(255);
        rd(128);
        rd(1);
        idle();
        repeat (4) step();

        // Asynchronous reset during a read.
        ce   = 1'b1;
        rw   = 1'b1;
        addr = 8'd0;
        step();
        idle();
        #2 clr = 1'b1;
        #1;
        chk("arst_rdvalid", {30'd0, rd_valid1, rd_valid2}, 32'd0);
        chk("arst_regout1", 32'(reg_out1), 32'd0);
        chk("arst_regout2", 32'(reg_out2), 32'd0);
        chk("arst_busy",    {30'd0, busy1, busy2}, 32'd3);
        chk("arst_ready",   {30'd0, load_ready1, load_ready2}, 32'd0);
        step();
        clr = 1'b0;
        wait_ready("arst_sweep");

        repeat (5) step();
        chk("drain_q1", q1.size(), 0);
        chk("drain_q2", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/prog_ram.md
PROG_RAM -- requirements
Module: prog_ram

Interface
REQ-001 Parameter ADDR_WIDTH, default 8, word address width; depth = 2**ADDR_WIDTH.
REQ-002 Parameter DATA_WIDTH, default 16, word width.
REQ-003 Parameter READ_LAT, default 1, read latency in cycles; legal values 1 or 2.
REQ-004 clk  input  1  single clock; all state changes on rising edge.
REQ-005 clr  input  1  reset, asynchronous, active-high.
REQ-006 ce  input  1  access enable; effective only in RUN.
REQ-007 rw  input  1  1 = read, 0 = write; sampled when ce=1.
REQ-008 addr  input  ADDR_WIDTH  access address.
REQ-009 reg_in  input  DATA_WIDTH  write data.
REQ-010 reg_out  output  DATA_WIDTH  read data; valid only while rd_valid=1.
REQ-011 rd_valid  output  1  one-cycle pulse per accepted read.
REQ-012 busy  output  1  high in CLEAR and LOAD; accesses ignored.
REQ-013 sweep_req  input  1  request full re-clear and reload, sampled in RUN.
REQ-014 load_valid  input  1  program-load word present.
REQ-015 load_data  input  DATA_WIDTH  program-load word.
REQ-016 load_last  input  1  marks final load word; qualified by load_valid.
REQ-017 load_ready  output  1  high only in LOAD.

Function
REQ-018 FSM states CLEAR, LOAD, RUN; no other reachable states.
REQ-019 CLEAR: counter writes 0 to one address per cycle, 0 to 2**ADDR_WIDTH-1 ascending; after the last address writes, next state is LOAD with load pointer = 0.
REQ-020 LOAD: a word transfers when load_valid and load_ready are both high in the same cycle; it is written at the load pointer, and the pointer increments.
REQ-021 LOAD exits to RUN on the cycle after a transfer with load_last=1, or after a transfer at address 2**ADDR_WIDTH-1 (no wrap; further words are not accepted).
REQ-022 load_valid=0 in LOAD: FSM holds; there is no timeout.
REQ-023 RUN write: ce=1, rw=0 writes reg_in to mem[addr] at that edge.
REQ-024 RUN read: ce=1, rw=1 captures addr; reg_out = mem[addr] and rd_valid=1 exactly READ_LAT cycles later.
REQ-025 Reads are fully pipelined; one read may be accepted every cycle.
REQ-026 Write in cycle N followed by a read of the same address in cycle N+1 returns the new data.
REQ-027 ce=0: no access; reg_out holds its last value; it is never driven to Z.
REQ-028 sweep_req=1 in RUN: next state is CLEAR, and any access in the same cycle is ignored.
REQ-029 In-flight reads at sweep_req are flushed; rd_valid does not pulse for them.
REQ-030 ce and sweep_req are ignored outside RUN; load_valid is ignored outside LOAD.

Reset
REQ-031 clr=1 asynchronously forces state CLEAR, clear counter 0, load pointer 0, reg_out 0, rd_valid 0, busy 1, load_ready 0, and the read pipeline empty.
REQ-032 After clr deasserts, the full CLEAR sweep runs; memory contents are not reset directly.
REQ-033 clr asserted mid-LOAD or mid-read abandons the operation; already-loaded words are overwritten by the sweep.

Structure
REQ-034 Shared package prog_ram_pkg holds the state enum (CLEAR, LOAD, RUN) and default parameter constants.
REQ-035 Sub-module prog_ram_array: single-port synchronous RAM (one write or one read per cycle), with no reset on its contents.
REQ-036 FSM, counters, read-latency pipeline and port muxing live in prog_ram.

Verification
REQ-037 Reset release -> busy=1 for exactly 256 cycles (AW=8), then load_ready=1.
REQ-038 Load 11 words 0x3803,0x0005,...,0x3C00 with load_last on the 11th -> RUN; reads of addr 0..10 return those words; addr 11..255 return 0.
REQ-039 READ_LAT=2: reads of addr 3,4,5 in consecutive cycles -> rd_valid on 3 consecutive cycles, 2 cycles later, with data in order.
REQ-040 Write 0xBEEF to addr 7, then read addr 7 on the next cycle -> 0xBEEF.
REQ-041 sweep_req with a read in flight -> no rd_valid, busy=1, memory all 0 after the sweep, load_ready=1.
REQ-042 256 load words without load_last -> RUN after word 256; a 257th load_valid is not accepted (load_ready=0).
